// File: rtl/frame_builder.sv
// Purpose : serialise one payload descriptor into a frame (HEADER, control, payload, CRC-16, TAIL) + idle gap.
// Latency : HEADER leaves one cycle after acceptance; frame is N+4 words, then GAP_WORDS idle words.
// Backpr. : frame_ack is high only in IDLE; a request presented while busy is simply held by the source.
//
// Ports:
//   clk_in, rst              - block clock, asynchronous active-high reset
//   frame_req / frame_ack    - descriptor valid / ready (accepted when both high on a rising edge)
//   payload, vld_ch,
//   word_num, crc_inject_err - descriptor fields, latched at acceptance
//   data_out, data_out_vld   - registered word stream and frame-word qualifier
//   busy                     - registered, high from acceptance until the gap has elapsed
//   frame_cnt                - registered count of completed frames (wraps)
module frame_builder #(
  parameter logic [15:0] HEADER    = 16'hEB90,
  parameter logic [15:0] TAIL      = 16'h55AA,
  parameter logic [15:0] IDLE_WORD = 16'h0000,
  parameter int unsigned GAP_WORDS = 2
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         frame_req,
  output logic         frame_ack,
  input  logic [127:0] payload,
  input  logic [7:0]   vld_ch,
  input  logic [3:0]   word_num,
  input  logic         crc_inject_err,
  output logic [15:0]  data_out,
  output logic         data_out_vld,
  output logic         busy,
  output logic [15:0]  frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_HEAD, S_CTRL, S_PAYLOAD, S_CRC, S_TAIL, S_GAP
  } state_t;

  localparam logic [3:0] GAP_LAST = 4'(GAP_WORDS);

  state_t        state_q, state_d;
  logic [127:0]  payload_q, payload_d;
  logic [7:0]    vld_ch_q, vld_ch_d;
  logic [3:0]    n_q, n_d;
  logic          err_q, err_d;
  logic [3:0]    idx_q, idx_d;
  logic [3:0]    gap_q, gap_d;
  logic [15:0]   crc_q, crc_d;
  logic [15:0]   data_out_q, data_out_d;
  logic          vld_q, vld_d;
  logic          busy_q, busy_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;

  logic [15:0]   pw [8];
  logic [15:0]   ctrl_word;
  logic [15:0]   crc_word;

  // One CCITT (0x1021) update over a full 16-bit word, MSB first.
  function automatic logic [15:0] crc16_upd(input logic [15:0] crc, input logic [15:0] d);
    logic [15:0] c;
    c = crc ^ d;
    for (int i = 0; i < 16; i++) begin
      c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      pw[k] = payload_q[127-16*k -: 16];
    end
  end

  assign ctrl_word = {vld_ch_q, 4'h0, n_q};
  assign crc_word  = crc_q ^ {16{err_q}};

  // The CRC register is advanced on the same edge a control/payload word is
  // loaded into data_out, so by the time the CRC state is entered it already
  // covers every word that was sent.
  always_comb begin
    state_d     = state_q;
    payload_d   = payload_q;
    vld_ch_d    = vld_ch_q;
    n_d         = n_q;
    err_d       = err_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    crc_d       = crc_q;
    data_out_d  = IDLE_WORD;
    vld_d       = 1'b0;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (frame_req) begin
          payload_d  = payload;
          vld_ch_d   = vld_ch;
          n_d        = (word_num > 4'd8) ? 4'd8 : word_num;
          err_d      = crc_inject_err;
          idx_d      = 4'd0;
          crc_d      = 16'hFFFF;
          state_d    = S_HEAD;
          data_out_d = HEADER;
          vld_d      = 1'b1;
        end
      end
      S_HEAD: begin
        state_d    = S_CTRL;
        data_out_d = ctrl_word;
        vld_d      = 1'b1;
        crc_d      = crc16_upd(crc_q, ctrl_word);
      end
      // CTRL and PAYLOAD share the same "next payload word or CRC" decision.
      S_CTRL, S_PAYLOAD: begin
        vld_d = 1'b1;
        if (idx_q < n_q) begin
          state_d    = S_PAYLOAD;
          data_out_d = pw[idx_q[2:0]];
          crc_d      = crc16_upd(crc_q, pw[idx_q[2:0]]);
          idx_d      = idx_q + 4'd1;
        end else begin
          state_d    = S_CRC;
          data_out_d = crc_word;
        end
      end
      S_CRC: begin
        state_d    = S_TAIL;
        data_out_d = TAIL;
        vld_d      = 1'b1;
      end
      S_TAIL: begin
        state_d     = S_GAP;
        gap_d       = 4'd1;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      payload_q   <= '0;
      vld_ch_q    <= '0;
      n_q         <= '0;
      err_q       <= 1'b0;
      idx_q       <= '0;
      gap_q       <= '0;
      crc_q       <= '0;
      data_out_q  <= IDLE_WORD;
      vld_q       <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      payload_q   <= payload_d;
      vld_ch_q    <= vld_ch_d;
      n_q         <= n_d;
      err_q       <= err_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      crc_q       <= crc_d;
      data_out_q  <= data_out_d;
      vld_q       <= vld_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_ack    = (state_q == S_IDLE);
  assign data_out     = data_out_q;
  assign data_out_vld = vld_q;
  assign busy         = busy_q;
  assign frame_cnt    = frame_cnt_q;

endmodule
